cache_arbiter: RTL and testbench

Two-requester, one-resource arbiter that shares the single L2/physical-memory line port between the L1 instruction cache (port A miss path) and the L1 data cache (port B miss/writeback path). It accepts one line-sized transaction at a time, steers the memory handshake to the granted cache, and uses round-robin on simultaneous requests so neither cache starves. It sits between the two L1 caches and the L2 cache, below the `cpu` memory ports.

---
 rtl/cache_arbiter.sv | 111 +++++++++++
 tb/tb_cache_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-requester line-port arbiter: steers the single L2 port between the L1 I-cache
// and L1 D-cache, one line transaction at a time, round-robin on ties.
module cache_arbiter #(
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   // instruction-cache side
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   // data-cache side
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   // memory side
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t state_q, state_d;
   // 0 = I-cache was served last, 1 = D-cache was served last
   logic   last_grant_q, last_grant_d;

   logic i_req;
   logic d_req;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   // Read data is broadcast; each cache qualifies it with its own resp.
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_address  = '0;
      mem_wdata    = '0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;

      case (state_q)
         IDLE: begin
            // mem_resp is deliberately ignored here
            if (i_req && d_req) begin
               state_d = last_grant_q ? SERVE_I : SERVE_D;
            end else if (i_req) begin
               state_d = SERVE_I;
            end else if (d_req) begin
               state_d = SERVE_D;
            end
         end

         SERVE_I: begin
            mem_read    = 1'b1;
            mem_address = i_address;
            if (mem_resp) begin
               i_resp       = 1'b1;
               last_grant_d = 1'b0;
               state_d      = IDLE;
            end
         end

         SERVE_D: begin
            // A writeback takes priority over a read raised at the same time.
            mem_write   = d_write;
            mem_read    = d_read & ~d_write;
            mem_address = d_address;
            mem_wdata   = d_wdata;
            if (mem_resp) begin
               d_resp       = 1'b1;
               last_grant_d = 1'b1;
               state_d      = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vector table, reset corner
// sequence, then randomized traffic against a transaction-level reference model.
module tb_cache_arbiter;

   localparam int LW = 256;
   localparam int AW = 32;

   logic          clk;
   logic          rst;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;

   int n_vec = 0;
   int n_err = 0;

   cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_read     (i_read),
      .i_address  (i_address),
      .i_rdata    (i_rdata),
      .i_resp     (i_resp),
      .d_read     (d_read),
      .d_write    (d_write),
      .d_address  (d_address),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_resp     (d_resp),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_address(mem_address),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_resp   (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ir dr dw mr | exp mem_read mem_write i_resp d_resp | addr source (0 none, 1 I, 2 D)
   typedef struct packed {
      logic       ir;
      logic       dr;
      logic       dw;
      logic       mr;
      logic       e_mr;
      logic       e_mw;
      logic       e_ir;
      logic       e_dr;
      logic [1:0] asel;
   } vec_t;

   localparam int NROWS = 22;
   vec_t tbl [NROWS];

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic e_mr, input logic e_mw,
                           input logic e_ir, input logic e_dr,
                           input logic [AW-1:0] e_addr, input logic [LW-1:0] e_wd);
      chk({tag, ".mem_read"},    LW'(mem_read),    LW'(e_mr));
      chk({tag, ".mem_write"},   LW'(mem_write),   LW'(e_mw));
      chk({tag, ".i_resp"},      LW'(i_resp),      LW'(e_ir));
      chk({tag, ".d_resp"},      LW'(d_resp),      LW'(e_dr));
      chk({tag, ".mem_address"}, LW'(mem_address), LW'(e_addr));
      chk({tag, ".mem_wdata"},   mem_wdata,        e_wd);
      chk({tag, ".i_rdata"},     i_rdata,          mem_rdata);
      chk({tag, ".d_rdata"},     d_rdata,          mem_rdata);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference model: who owns the port (0 nobody, 1 I-cache, 2 D-cache) and
   // which side most recently finished (1 I-cache, 2 D-cache).
   int owner;
   int last_done;

   task automatic model_step();
      if (owner == 0) begin
         if (i_read && (d_read || d_write)) owner = (last_done == 2) ? 1 : 2;
         else if (i_read)                   owner = 1;
         else if (d_read || d_write)        owner = 2;
      end else if (mem_resp) begin
         last_done = owner;
         owner     = 0;
      end
   endtask

   task automatic model_check(input string tag);
      logic          e_mr, e_mw, e_ir, e_dr;
      logic [AW-1:0] e_addr;
      logic [LW-1:0] e_wd;
      e_mr = 1'b0; e_mw = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
      e_addr = '0; e_wd = '0;
      if (owner == 1) begin
         e_mr   = 1'b1;
         e_addr = i_address;
         e_ir   = mem_resp;
      end else if (owner == 2) begin
         e_mw   = d_write;
         e_mr   = d_read && !d_write;
         e_addr = d_address;
         e_wd   = d_wdata;
         e_dr   = mem_resp;
      end
      chk_outs(tag, e_mr, e_mw, e_ir, e_dr, e_addr, e_wd);
   endtask

   localparam logic [AW-1:0] IA = 32'h0000_1040;
   localparam logic [AW-1:0] DA = 32'h8000_0020;

   initial begin
      logic [LW-1:0] pat_a;
      logic [LW-1:0] pat_b;
      logic [AW-1:0] e_addr;
      logic [LW-1:0] e_wd;

      pat_a = {8{32'hA5A5_0F0F}};
      pat_b = {8{32'h3C3C_9696}};

      tbl[0]  = 10'b1000_0000_00;  // I request seen in IDLE
      tbl[1]  = 10'b1000_1000_01;
      tbl[2]  = 10'b1000_1000_01;
      tbl[3]  = 10'b1001_1010_01;  // L2 answers after 3 cycles
      tbl[4]  = 10'b0010_0000_00;  // idle bubble, D writeback seen
      tbl[5]  = 10'b0010_0100_10;
      tbl[6]  = 10'b0011_0101_10;
      tbl[7]  = 10'b1100_0000_00;  // tie, last was D -> I
      tbl[8]  = 10'b1101_1010_01;
      tbl[9]  = 10'b1100_0000_00;  // tie, last was I -> D
      tbl[10] = 10'b1101_1001_10;
      tbl[11] = 10'b1100_0000_00;  // tie -> I again
      tbl[12] = 10'b1101_1010_01;
      tbl[13] = 10'b0110_0000_00;  // read+write together
      tbl[14] = 10'b0110_0100_10;
      tbl[15] = 10'b0111_0101_10;
      tbl[16] = 10'b0001_0000_00;  // spurious mem_resp in IDLE
      tbl[17] = 10'b0000_0000_00;
      tbl[18] = 10'b1000_0000_00;  // I transaction leaves last grant = I
      tbl[19] = 10'b1001_1010_01;
      tbl[20] = 10'b0010_0000_00;  // D-only grant, to be cut by reset
      tbl[21] = 10'b0010_0100_10;

      rst = 1'b1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
      i_address = IA; d_address = DA; d_wdata = pat_b; mem_rdata = pat_a;
      owner = 0; last_done = 2;

      #1;
      chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int r = 0; r < NROWS; r++) begin
         if (r != 0) @(negedge clk);
         i_read = tbl[r].ir; d_read = tbl[r].dr; d_write = tbl[r].dw; mem_resp = tbl[r].mr;
         #1;
         e_addr = (tbl[r].asel == 2'd1) ? IA : (tbl[r].asel == 2'd2) ? DA : '0;
         e_wd   = (tbl[r].asel == 2'd2) ? pat_b : '0;
         chk_outs($sformatf("row%0d", r), tbl[r].e_mr, tbl[r].e_mw, tbl[r].e_ir,
                  tbl[r].e_dr, e_addr, e_wd);
      end

      // Asynchronous reset in the middle of a D writeback.
      @(posedge clk);
      #2;
      mem_resp = 1'b1;
      rst = 1'b1;
      #1;
      chk_outs("rst_mid_d", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rst = 1'b0; mem_resp = 1'b0;
      i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
      #1;
      chk_outs("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      #1;
      chk_outs("post_rst_tie_i", 1'b1, 1'b0, 1'b0, 1'b0, IA, '0);
      mem_resp = 1'b1;
      #1;
      chk_outs("post_rst_i_resp", 1'b1, 1'b0, 1'b1, 1'b0, IA, '0);

      // Randomized traffic against the reference model.
      @(negedge clk);
      rst = 1'b1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      owner = 0; last_done = 2;
      for (int c = 0; c < 3000; c++) begin
         i_read    = ($urandom_range(0, 2) != 0);
         d_read    = ($urandom_range(0, 1) != 0);
         d_write   = ($urandom_range(0, 3) == 0);
         mem_resp  = ($urandom_range(0, 2) == 0);
         i_address = $urandom;
         d_address = $urandom;
         d_wdata   = rand_line();
         mem_rdata = rand_line();
         #1;
         model_check($sformatf("rand%0d", c));
         model_step();
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
